mem_access_unit: RTL and testbench

Load/store sequencer directly upstream of the word-addressed data memory in the multicycle MIPS datapath. Accepts byte-addressed requests of any width (byte, half, word) from the datapath control and drives the memory's word address, write data, we and re. Performs alignment checks, big-endian lane extraction with sign or zero extension for loads, and read-modify-write sequencing for partial stores, because the memory supports only full-word writes.

---
 rtl/mem_access_unit_pkg.sv | 27 ++
 rtl/mem_access_unit_lane_align.sv | 62 ++++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MIPS load/store sequencer and its lane aligner.
// Lanes are numbered big-endian: offset 0 is the most significant byte of the word.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } lsu_state_t;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic [1:0] LANE_H0 = 2'd0;
    localparam logic [1:0] LANE_H1 = 2'd2;

    localparam logic [1:0] SIZE_RESERVED = 2'b11;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational big-endian lane logic: extracts and extends a load lane, and
// merges store data into the addressed lane(s) of an existing word.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (offset)
            LANE_B0: byte_lane = word[31:24];
            LANE_B1: byte_lane = word[23:16];
            LANE_B2: byte_lane = word[15:8];
            LANE_B3: byte_lane = word[7:0];
            default: byte_lane = 8'h00;
        endcase
        half_lane = (offset == LANE_H1) ? word[15:0] : word[31:16];
    end

    // A word access (or anything not byte/half) passes straight through both paths.
    always_comb begin
        load_val   = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_val   = {{24{sign_ext & byte_lane[7]}}, byte_lane};
                store_word = word;
                case (offset)
                    LANE_B0: store_word[31:24] = wdata[7:0];
                    LANE_B1: store_word[23:16] = wdata[7:0];
                    LANE_B2: store_word[15:8]  = wdata[7:0];
                    LANE_B3: store_word[7:0]   = wdata[7:0];
                    default: store_word        = word;
                endcase
            end
            SZ_HALF: begin
                load_val   = {{16{sign_ext & half_lane[15]}}, half_lane};
                store_word = word;
                if (offset == LANE_H1) begin
                    store_word[15:0] = wdata[15:0];
                end else begin
                    store_word[31:16] = wdata[15:0];
                end
            end
            default: begin
                load_val   = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-only data memory: alignment checks,
// load lane extraction, and read-modify-write for byte/half stores.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    lsu_state_t  state;
    lsu_state_t  next_state;
    logic        wr_q;
    logic        sign_q;
    logic        err_q;
    size_t       size_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        reject;
    logic [31:0] load_val;
    logic [31:0] store_word;

    assign reject = (size == SIZE_RESERVED)
                  | ((size == SZ_HALF) & addr[0])
                  | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                  | ({1'b0, addr} >= ADDR_LIMIT);

    assign accept = (state == IDLE) & req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (reject) begin
                        next_state = RESP;
                    end else if (wr && (size == SZ_WORD)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = wr_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes come from state alone so a reset drops them immediately.
    always_comb begin
        ready  = (state == IDLE);
        mem_re = (state == READ);
        mem_we = (state == WRITE);
        done   = (state == RESP);
        err    = (state == RESP) & err_q;
    end

    lsu_lane_align u_lane_align (
        .word       (mem_rdata),
        .offset     (offset_q),
        .size       (size_q),
        .sign_ext   (sign_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // The read word is consumed on the READ edge: loads update rdata,
    // partial stores register the merged word for the following WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= SZ_BYTE;
            offset_q  <= 2'b00;
            wdata_q   <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
        end else begin
            if (accept) begin
                wr_q     <= wr;
                sign_q   <= sign_ext;
                err_q    <= reject;
                size_q   <= size_t'(size);
                offset_q <= addr[1:0];
                wdata_q  <= wdata;
                if (!reject) begin
                    mem_addr  <= {2'b00, addr[31:2]};
                    mem_wdata <= wdata;
                end
            end
            if (state == READ) begin
                if (wr_q) begin
                    mem_wdata <= store_word;
                end else begin
                    rdata <= load_val;
                end
            end
        end
    end

    a_no_we_and_re: assert property (@(posedge clk) disable iff (!rst_n) !(mem_we && mem_re));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural memory and a
// byte-lane arithmetic reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    wire  [31:0] mem_rdata;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_rdata;
    int          asserts;
    int          fails;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end
    assign mem_rdata = mem_re ? mem[mem_addr[9:0]] : 'z;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sx);
        int unsigned bits, sh;
        logic [31:0] lo_mask, v;
        if (sz == 2'd2) return w;
        bits    = (sz == 2'd0) ? 8 : 16;
        sh      = 32 - bits - 8 * off;
        lo_mask = (32'h1 << bits) - 32'h1;
        v       = (w >> sh) & lo_mask;
        if (sx && v[bits-1]) v = v | ~lo_mask;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] off,
                                                input logic [1:0] sz, input logic [31:0] wd);
        int unsigned bits, sh;
        logic [31:0] mask;
        if (sz == 2'd2) return wd;
        bits = (sz == 2'd0) ? 8 : 16;
        sh   = 32 - bits - 8 * off;
        mask = ((32'h1 << bits) - 32'h1) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Predicts the outcome of one transaction and advances the reference state.
    task automatic model_apply(input logic t_wr, input logic [1:0] t_size, input logic t_sx,
                               input logic [31:0] t_addr, input logic [31:0] t_wdata,
                               output logic e_err, output int e_cyc, output int e_re, output int e_we);
        int idx;
        e_err = (t_size == 2'd3) || (t_size == 2'd1 && t_addr[0]) ||
                (t_size == 2'd2 && t_addr[1:0] != 2'd0) || (t_addr >= 32'd4096);
        idx = int'(t_addr >> 2);
        if (e_err) begin
            e_cyc = 1; e_re = 0; e_we = 0;
        end else if (!t_wr) begin
            e_cyc = 2; e_re = 1; e_we = 0;
            exp_rdata = model_load(ref_mem[idx], t_addr[1:0], t_size, t_sx);
        end else begin
            e_cyc = (t_size == 2'd2) ? 2 : 3;
            e_re  = (t_size == 2'd2) ? 0 : 1;
            e_we  = 1;
            ref_mem[idx] = model_store(ref_mem[idx], t_addr[1:0], t_size, t_wdata);
        end
    endtask

    task automatic run_txn(input logic t_wr, input logic [1:0] t_size, input logic t_sx,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           output int cyc, output logic t_err, output logic [31:0] t_rd,
                           output int re_n, output int we_n, output logic [31:0] re_addr,
                           output logic [31:0] we_data, output logic both);
        @(negedge clk);
        req = 1'b1; wr = t_wr; size = t_size; sign_ext = t_sx; addr = t_addr; wdata = t_wdata;
        cyc = -1; t_err = 1'b0; t_rd = 32'h0; re_n = 0; we_n = 0;
        re_addr = 32'h0; we_data = 32'h0; both = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem_re) begin re_n++; re_addr = mem_addr; end
            if (mem_we) begin we_n++; we_data = mem_wdata; end
            if (mem_re && mem_we) both = 1'b1;
            if (done) begin
                cyc = c; t_err = err; t_rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        exp_rdata = 32'h0;
        #12;
        asserts++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        asserts++; if ({done, err, mem_we, mem_re} !== 4'b0000) begin fails++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {done, err, mem_we, mem_re}); end
        asserts++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata); end
        asserts++; if ({mem_addr, mem_wdata} !== 64'h0) begin fails++; $display("[TB] FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        int cyc, re_n, we_n, e_cyc, e_re, e_we;
        logic t_err, both, e_err;
        logic [31:0] rd, re_addr, we_data;
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;

        model_apply(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, e_err, e_cyc, e_re, e_we);
        run_txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
        asserts++; if (cyc !== 2) begin fails++; $display("[TB] FAIL lb_sx_latency: got %0d expected 2", cyc); end
        asserts++; if (rd !== 32'hFFFFFF99) begin fails++; $display("[TB] FAIL lb_sx_rdata: got %h expected FFFFFF99", rd); end

        model_apply(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, e_err, e_cyc, e_re, e_we);
        run_txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
        asserts++; if (rd !== 32'h00000099) begin fails++; $display("[TB] FAIL lb_zx_rdata: got %h expected 00000099", rd); end

        model_apply(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, e_err, e_cyc, e_re, e_we);
        run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
        asserts++; if (rd !== 32'hFFFFAABB) begin fails++; $display("[TB] FAIL lh_sx_rdata: got %h expected FFFFAABB", rd); end

        model_apply(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_cyc, e_re, e_we);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
        asserts++; if (rd !== 32'h8899AABB) begin fails++; $display("[TB] FAIL lw_rdata: got %h expected 8899AABB", rd); end
        asserts++; if (re_n !== 1 || re_addr !== 32'd4) begin fails++; $display("[TB] FAIL lw_mem_addr: got %0d reads at %h expected 1 read at 00000004", re_n, re_addr); end
        asserts++; if (cyc !== 2) begin fails++; $display("[TB] FAIL lw_latency: got %0d expected 2", cyc); end
    endtask

    task automatic test_partial_store();
        int cyc, re_n, we_n, e_cyc, e_re, e_we;
        logic t_err, both, e_err;
        logic [31:0] rd, re_addr, we_data;
        model_apply(1'b1, 2'd0, 1'b0, 32'h13, 32'h5A, e_err, e_cyc, e_re, e_we);
        run_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h5A, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
        asserts++; if (cyc !== 3) begin fails++; $display("[TB] FAIL sb_latency: got %0d expected 3", cyc); end
        asserts++; if (re_n !== 1 || we_n !== 1) begin fails++; $display("[TB] FAIL sb_rmw: got %0d reads %0d writes expected 1 and 1", re_n, we_n); end
        asserts++; if (we_data !== 32'h8899AA5A) begin fails++; $display("[TB] FAIL sb_mem_wdata: got %h expected 8899AA5A", we_data); end
        asserts++; if (rd !== exp_rdata) begin fails++; $display("[TB] FAIL sb_rdata_held: got %h expected %h", rd, exp_rdata); end
        model_apply(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_cyc, e_re, e_we);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
        asserts++; if (rd !== 32'h8899AA5A) begin fails++; $display("[TB] FAIL sb_readback: got %h expected 8899AA5A", rd); end
    endtask

    task automatic test_reject();
        logic [31:0] r_addr [4] = '{32'h11, 32'h12, 32'h10, 32'h1000};
        logic [1:0]  r_size [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic        r_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int cyc, re_n, we_n, e_cyc, e_re, e_we;
        logic t_err, both, e_err;
        logic [31:0] rd, re_addr, we_data;
        for (int i = 0; i < 4; i++) begin
            model_apply(r_wr[i], r_size[i], 1'b1, r_addr[i], 32'hDEADBEEF, e_err, e_cyc, e_re, e_we);
            run_txn(r_wr[i], r_size[i], 1'b1, r_addr[i], 32'hDEADBEEF, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
            asserts++; if (cyc !== 1 || t_err !== 1'b1) begin fails++; $display("[TB] FAIL reject%0d_done_err: got cyc %0d err %b expected cyc 1 err 1", i, cyc, t_err); end
            asserts++; if (re_n !== 0 || we_n !== 0) begin fails++; $display("[TB] FAIL reject%0d_strobes: got %0d reads %0d writes expected 0 and 0", i, re_n, we_n); end
            asserts++; if (rd !== exp_rdata) begin fails++; $display("[TB] FAIL reject%0d_rdata: got %h expected %h", i, rd, exp_rdata); end
        end
    endtask

    task automatic test_back_to_back();
        int done_at, re_n, we_n, e_cyc, e_re, e_we;
        logic e_err;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h2; wdata = 32'h000000C3;
        model_apply(1'b1, 2'd0, 1'b0, 32'h2, 32'h000000C3, e_err, e_cyc, e_re, e_we);
        done_at = -1; re_n = 0; we_n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_re) re_n++;
            if (mem_we) we_n++;
            if (done) begin done_at = c; break; end
        end
        asserts++; if (done_at !== 3 || re_n !== 1 || we_n !== 1) begin fails++; $display("[TB] FAIL b2b_single_txn: got done %0d reads %0d writes %0d expected 3/1/1", done_at, re_n, we_n); end
        wr = 1'b0; size = 2'd2; addr = 32'h0;
        model_apply(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, e_err, e_cyc, e_re, e_we);
        @(negedge clk);
        asserts++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready_after_done: got %b expected 1", ready); end
        done_at = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (done) begin done_at = c; break; end
        end
        asserts++; if (done_at !== 2 || rdata !== exp_rdata) begin fails++; $display("[TB] FAIL b2b_second_lw: got done %0d rdata %h expected 2 %h", done_at, rdata, exp_rdata); end
    endtask

    task automatic test_random();
        int cyc, re_n, we_n, e_cyc, e_re, e_we;
        logic t_err, both, e_err, r_wr, r_sx;
        logic [1:0] r_size;
        logic [31:0] rd, re_addr, we_data, r_addr, r_wdata;
        int bad;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        for (int n = 0; n < 150; n++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_sx    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_wdata = $urandom;
            r_addr  = ($urandom_range(0, 9) == 0) ? 32'd4096 + $urandom_range(0, 255) : 32'($urandom_range(0, 63));
            model_apply(r_wr, r_size, r_sx, r_addr, r_wdata, e_err, e_cyc, e_re, e_we);
            run_txn(r_wr, r_size, r_sx, r_addr, r_wdata, cyc, t_err, rd, re_n, we_n, re_addr, we_data, both);
            asserts++;
            if (cyc !== e_cyc || t_err !== e_err || rd !== exp_rdata || re_n !== e_re || we_n !== e_we || both !== 1'b0) begin
                fails++;
                $display("[TB] FAIL rand%0d wr=%b sz=%0d a=%h: got cyc %0d err %b rd %h r/w %0d/%0d both %b expected cyc %0d err %b rd %h r/w %0d/%0d both 0",
                         n, r_wr, r_size, r_addr, cyc, t_err, rd, re_n, we_n, both, e_cyc, e_err, exp_rdata, e_re, e_we);
            end
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad++;
        asserts++; if (bad !== 0) begin fails++; $display("[TB] FAIL rand_memory_image: got %0d differing words expected 0", bad); end
    endtask

    task automatic test_reset_mid_write();
        int spurious;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h15; wdata = 32'h000000E7;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        asserts++; if (mem_we !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid_write_setup: got mem_we %b expected 1", mem_we); end
        rst_n = 1'b0;
        #1;
        asserts++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_drop: got we %b re %b expected 0 0", mem_we, mem_re); end
        @(negedge clk);
        asserts++; if (mem[5] !== ref_mem[5]) begin fails++; $display("[TB] FAIL rst_mem_unchanged: got %h expected %h", mem[5], ref_mem[5]); end
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        spurious = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || ready !== 1'b1) spurious++;
        end
        asserts++; if (spurious !== 0) begin fails++; $display("[TB] FAIL rst_no_done_ready: got %0d bad cycles expected 0", spurious); end
        asserts++; if (rdata !== exp_rdata) begin fails++; $display("[TB] FAIL rst_rdata_cleared: got %h expected %h", rdata, exp_rdata); end
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        test_reset();
        test_loads();
        test_partial_store();
        test_reject();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
